// File: rtl/sign_normalizer_iter.sv
`default_nettype none
// ============================================================================
// Module  : sign_normalizer_iter
// Brief   : Iterative left-normaliser (signed / unsigned), one binary-search
//           step per clock, valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module sign_normalizer_iter #(
    parameter int WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_signed,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic [$clog2(WIDTH):0]  o_shift,
    output logic                    o_zero
);
    localparam int L  = $clog2(WIDTH);
    localparam int CW = L + 1;
    localparam int KW = $clog2(L);

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "sign_normalizer_iter: WIDTH must be a power of two in 8..64");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [CW-1:0]    r_cnt;
    logic [KW-1:0]    r_k;
    logic             r_sgn;
    logic             r_zero;
    logic             r_ready;
    logic             r_valid;

    logic [L-1:0]     w_stest;
    logic [L-1:0]     w_utest;
    logic             w_take;
    logic [CW-1:0]    w_step;

    // Per-step tests: signed looks at 2^j+1 top bits, unsigned at 2^j.
    for (genvar j = 0; j < L; j++) begin : g_test
        localparam int N = 1 << j;
        assign w_utest[j] = (r_work[WIDTH-1 -: N] == '0);
        assign w_stest[j] = (r_work[WIDTH-1 -: N+1] == '0) ||
                            (r_work[WIDTH-1 -: N+1] == '1);
    end

    assign w_take = r_sgn ? w_stest[r_k] : w_utest[r_k];
    assign w_step = {{(CW-1){1'b0}}, 1'b1} << r_k;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_sgn   <= 1'b0;
            r_zero  <= 1'b0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_work  <= i_data;
                        r_sgn   <= i_signed;
                        r_cnt   <= '0;
                        r_k     <= KW'(L - 1);
                        r_zero  <= (i_data == '0);
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_take) begin
                        r_work <= r_work << w_step;
                    end
                    // The search tops out at WIDTH-1; unsigned zero reports WIDTH.
                    if (r_k == '0 && r_zero && !r_sgn) begin
                        r_cnt <= CW'(WIDTH);
                    end else if (w_take) begin
                        r_cnt <= r_cnt + w_step;
                    end
                    if (r_k == '0) begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_work;
    assign o_shift = r_cnt;
    assign o_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_sign_normalizer_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sign_normalizer_iter
// Brief   : Directed-vector and corner-sequence bench for sign_normalizer_iter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sign_normalizer_iter;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        down_ready;
    logic [31:0] out_data;
    logic [5:0]  out_shift;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    sign_normalizer_iter #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_data   (in_data),
        .i_signed (in_signed),
        .o_valid  (out_valid),
        .i_ready  (down_ready),
        .o_data   (out_data),
        .o_shift  (out_shift),
        .o_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic [31:0] ed;
        logic [5:0]  esh;
        logic        ez;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: count leading sign / zero bits directly.
    function automatic void ref_norm(input logic [31:0] d, input logic s,
                                     output logic [31:0] od, output logic [5:0] sh);
        int n = 0;
        if (s) begin
            while (n < 31 && d[30-n] == d[31]) n++;
        end else if (d == 0) begin
            n = 32;
        end else begin
            while (d[31-n] == 1'b0) n++;
        end
        od = (n == 32) ? 32'h0 : (d << n);
        sh = 6'(n);
    endfunction

    // Called just after a rising edge with the DUT idle; leaves it idle again.
    task automatic do_op(input logic [31:0] d, input logic s, input int stall,
                         output logic [31:0] od, output logic [5:0] osh,
                         output logic oz, output int lat);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        od  = out_data;
        osh = out_shift;
        oz  = out_zero;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {out_valid, out_data, out_shift, out_zero},
                  {1'b1, od, osh, oz});
        end
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
    endtask

    logic [31:0] od, rd, hold_d;
    logic [5:0]  osh, rsh, hold_sh;
    logic        oz;
    int          lat;
    logic [31:0] rnd;
    logic        rs;

    initial begin
        vecs[0] = '{32'h0000_00FF, 1'b1, 32'h7F80_0000, 6'd23, 1'b0};
        vecs[1] = '{32'hFFFF_FF00, 1'b1, 32'h8000_0000, 6'd23, 1'b0};
        vecs[2] = '{32'h4000_0000, 1'b1, 32'h4000_0000, 6'd0,  1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0};
        vecs[4] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd31, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1};
        vecs[6] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0};
        vecs[7] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0};
        vecs[8] = '{32'h0001_2345, 1'b0, 32'h91A2_8000, 6'd15, 1'b0};
        vecs[9] = '{32'hC000_0000, 1'b1, 32'h8000_0000, 6'd1,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; down_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {out_ready, out_valid, out_data, out_shift, out_zero},
              {1'b1, 1'b0, 32'h0, 6'd0, 1'b0});
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            check("ready_before", out_ready, 1'b1);
            do_op(vecs[i].d, vecs[i].s, 0, od, osh, oz, lat);
            check($sformatf("v%0d_data", i), od, vecs[i].ed);
            check($sformatf("v%0d_shift", i), osh, vecs[i].esh);
            check($sformatf("v%0d_zero", i), oz, vecs[i].ez);
            check($sformatf("v%0d_latency", i), lat, 5);
        end

        // Back-pressure: result held 10 cycles, stray i_valid ignored.
        in_valid = 1'b1; in_data = 32'h0000_0F00; in_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_valid", out_valid, 1'b1);
        hold_d = out_data; hold_sh = out_shift;
        check("bp_data", hold_d, 32'hF000_0000);
        check("bp_shift", hold_sh, 6'd20);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 4);
            in_data  = 32'h0000_0003;
            @(posedge clk); #1;
            check("bp_hold", {out_valid, out_ready, out_data, out_shift},
                  {1'b1, 1'b0, hold_d, hold_sh});
        end
        in_valid = 1'b0;
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        check("bp_drain", {out_valid, out_ready}, {1'b0, 1'b1});
        do_op(32'h0000_0003, 1'b1, 0, od, osh, oz, lat);
        check("bp_next_data", od, 32'h6000_0000);
        check("bp_next_shift", osh, 6'd29);

        // Reset two cycles into RUN aborts the operation.
        in_valid = 1'b1; in_data = 32'h0000_0001; in_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_reset", {out_ready, out_valid, out_data, out_shift, out_zero},
              {1'b1, 1'b0, 32'h0, 6'd0, 1'b0});
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("abort_no_valid", {out_valid, out_ready}, {1'b0, 1'b1});
        end

        // Random operands against the reference model, random stalls.
        for (int n = 0; n < 300; n++) begin
            rnd = $urandom >> $urandom_range(0, 32 - 1);
            rs  = $urandom_range(0, 1);
            if (rs && $urandom_range(0, 1)) rnd = ~rnd;
            if (n % 50 == 0) rnd = 32'h0;
            ref_norm(rnd, rs, rd, rsh);
            do_op(rnd, rs, $urandom_range(0, 3), od, osh, oz, lat);
            check("rnd_data", od, rd);
            check("rnd_shift", osh, rsh);
            check("rnd_zero", oz, rnd == 32'h0);
            check("rnd_latency", lat, 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sign_normalizer_iter.md
Name: sign_normalizer_iter

Overview:
- Parametrised, sequential successor to the divider's combinational normalisation shifter.
- Accepts one operand per transaction over a valid/ready handshake.
- Left-normalises the operand in either signed mode (removes redundant sign bits) or unsigned mode (removes leading zeros), using one binary-search step per clock.
- Returns the normalised word and the shift count, which feed the divider's iteration-count and quotient-alignment logic.

Parameters:
- WIDTH, 32: operand width. Must be a power of two, 8..64; other values are a fatal elaboration error.
- L, $clog2(WIDTH): number of search steps (derived localparam, not overridable).
- CW, $clog2(WIDTH)+1: width of the shift-count output (derived localparam).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  input operand valid.
- o_ready  out  1  block can accept an operand.
- i_data  in  WIDTH  operand.
- i_signed  in  1  1 = signed normalisation, 0 = unsigned; sampled with the operand.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_data  out  WIDTH  normalised operand.
- o_shift  out  CW  number of bit positions shifted left.
- o_zero  out  1  the accepted operand was all zeros.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low on i_rst_n, sampled at the rising edge of i_clk.
- Reset values: FSM = IDLE, o_valid=0, o_data=0, o_shift=0, o_zero=0. After the reset edge, o_ready=1.
- Reset mid-operation: reset applied in RUN or DONE aborts the operation and discards the result; no o_valid pulse follows.
- FSM states: IDLE, RUN, DONE. o_ready=1 only in IDLE. o_valid=1 only in DONE.
- IDLE:
  - On i_valid&&o_ready, latch i_data into a work register, latch i_signed, clear the count, set step k=L-1, set o_zero = (i_data==0), then go to RUN.
  - i_valid with o_ready=0 is ignored; no internal queueing.
- RUN, one step per cycle at step k:
  - Signed test: the top 2^k+1 bits of the work register are all equal.
  - Unsigned test: the top 2^k bits are all zero.
  - If the test is true, shift the work register left by 2^k (zero fill) and add 2^k to the count.
  - Then decrement k. After the k=0 step, go to DONE.
- RUN duration: exactly L cycles regardless of the data; no early exit.
- Unsigned zero operand: the final count is forced to WIDTH (the binary search alone reaches only WIDTH-1), and o_data=0.
- Signed zero and signed all-ones operands: count = WIDTH-1. o_data = 0 for zero, 1<<(WIDTH-1) for all-ones.
- Result invariant (non-zero, non-all-ones operand):
  - Signed: o_data[WIDTH-1] != o_data[WIDTH-2], and o_data = i_data<<o_shift.
  - Unsigned: o_data[WIDTH-1]=1.
- Latency: o_valid rises on the L-th rising edge after the accepting edge (WIDTH=32: edge +5).
- DONE: o_data, o_shift and o_zero are registered and held stable while o_valid&&!i_ready.
  - On i_ready, go to IDLE next edge. o_ready rises then, so the next accept is possible one edge later.
  - Throughput: one operand per L+2 cycles minimum.
- Handshake rules: i_ready may be high early; it is ignored outside DONE. i_signed and i_data are don't-care outside the accept cycle.
- Counts: o_shift is an unsigned CW-bit value, range 0..WIDTH (WIDTH only for unsigned zero). No wrap-around is possible.

Test Plan:
- WIDTH=32, signed, i_data=0x0000_00FF -> o_data=0x7F80_0000, o_shift=23, o_zero=0; o_valid exactly 5 edges after accept.
- Signed 0xFFFF_FF00 -> o_data=0x8000_0000, o_shift=23. Signed 0x4000_0000 -> o_shift=0, data unchanged. Signed 0xFFFF_FFFF -> o_data=0x8000_0000, o_shift=31.
- Zero operand: signed 0 -> o_data=0, o_shift=31, o_zero=1. Unsigned 0 -> o_data=0, o_shift=32, o_zero=1. Unsigned 0x0000_0001 -> o_data=0x8000_0000, o_shift=31.
- Back-pressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and outputs stay stable, o_ready=0, and a pulsed i_valid is ignored. Raising i_ready drains the result, o_ready=1 next cycle, and the next operand is accepted.
- Reset mid-RUN: drop i_rst_n two cycles after accept -> all outputs return to reset values, o_ready=1 after reset release, and no o_valid ever appears for the aborted operand.
- Random regression at WIDTH=8, 16, 32 and 64, both modes: compare against a reference model (count leading sign/zero bits, shift) over at least 10k operands with random i_ready.
